// File: rtl/uart_pkg.sv
// uart_pkg: shared types and helpers for the uart_xcvr block.
//   - uart_tx_state_t / uart_rx_state_t : FSM state encodings
//   - PAR_NONE / PAR_EVEN / PAR_ODD     : parity mode selectors
//   - calc_div()                        : clocks per oversampling tick, rounded
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_PARITY,
    TX_STOP
  } uart_tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP,
    RX_WAIT_HIGH
  } uart_rx_state_t;

  // round(clk_freq / (baud_rate * oversample)); 64-bit math avoids overflow
  // for fast system clocks.
  function automatic int calc_div(input int clk_freq, input int baud_rate,
                                  input int oversample);
    longint den;
    den = longint'(baud_rate) * longint'(oversample);
    return int'((longint'(clk_freq) + den / 2) / den);
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: oversampling tick generator shared by the TX and RX paths.
// Ports:
//   clk     : system clock
//   reset_n : synchronous active-low reset (counter -> 0)
//   restart : restart the divider so the next tick is DIV clocks away
//   tick    : one-cycle pulse every DIV clocks (constantly high when DIV=1)
module uart_baud_gen #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_reg, cnt_next;

  always_comb begin
    if (restart || cnt_reg == CNT_LAST) cnt_next = '0;
    else                                cnt_next = cnt_reg + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) cnt_reg <= '0;
    else          cnt_reg <= cnt_next;
  end

  assign tick = (cnt_reg == CNT_LAST);

endmodule

// File: rtl/uart_xcvr.sv
// uart_xcvr: parametrised full-duplex UART.
// Ports:
//   clk, reset_n                     : system clock, synchronous active-low reset
//   uart_rx / uart_tx                : serial line in (async) / out (registered), idle high
//   tx_data, tx_valid, tx_ready      : transmit handshake; byte taken when valid && ready
//   rx_data, rx_valid                : received payload, one-cycle valid pulse
//   rx_parity_err, rx_frame_err      : per-frame error flags, held until next rx_valid
module uart_xcvr
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 65000000,
  parameter int BAUD_RATE  = 230400,
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 uart_rx,
  output logic                 uart_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int OW  = $clog2(OVERSAMPLE);
  localparam int IW  = $clog2(DATA_BITS);
  localparam logic [OW-1:0] OS_LAST   = OW'(OVERSAMPLE - 1);
  localparam logic [OW-1:0] OS_HALF   = OW'(OVERSAMPLE / 2 - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  if (DIV < 1) begin : g_div_check
    $fatal(1, "uart_xcvr: clock too slow for requested baud rate and oversampling");
  end

  logic tick;
  logic tx_handshake;

  // Restarting on a handshake aligns the first TX bit to a full tick period.
  uart_baud_gen #(.DIV(DIV)) u_baud_gen (
    .clk     (clk),
    .reset_n (reset_n),
    .restart (tx_handshake),
    .tick    (tick)
  );

  // ---------------------------------------------------------------- TX path
  uart_tx_state_t       tx_state_reg, tx_state_next;
  logic [OW-1:0]        tx_os_reg, tx_os_next;
  logic [IW-1:0]        tx_idx_reg, tx_idx_next;
  logic [DATA_BITS-1:0] tx_data_reg, tx_data_next;
  logic                 uart_tx_reg, uart_tx_next;
  logic                 tx_par;

  assign tx_ready     = (tx_state_reg == TX_IDLE);
  assign tx_handshake = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      tx_state_reg <= TX_IDLE;
      tx_os_reg    <= '0;
      tx_idx_reg   <= '0;
      tx_data_reg  <= '0;
      uart_tx_reg  <= 1'b1;
    end else begin
      tx_state_reg <= tx_state_next;
      tx_os_reg    <= tx_os_next;
      tx_idx_reg   <= tx_idx_next;
      tx_data_reg  <= tx_data_next;
      uart_tx_reg  <= uart_tx_next;
    end
  end

  // tx_idx counts data bits in DATA and stop bits in STOP.
  always_comb begin
    tx_state_next = tx_state_reg;
    tx_os_next    = tx_os_reg;
    tx_idx_next   = tx_idx_reg;
    tx_data_next  = tx_data_reg;
    if (tx_state_reg == TX_IDLE) begin
      if (tx_valid) begin
        tx_state_next = TX_START;
        tx_os_next    = '0;
        tx_idx_next   = '0;
        tx_data_next  = tx_data;
      end
    end else if (tick) begin
      tx_os_next = tx_os_reg + 1'b1;
      if (tx_os_reg == OS_LAST) begin
        tx_os_next = '0;
        case (tx_state_reg)
          TX_START:  tx_state_next = TX_DATA;
          TX_DATA: begin
            if (tx_idx_reg == DATA_LAST) begin
              tx_idx_next   = '0;
              tx_state_next = (PARITY != PAR_NONE) ? TX_PARITY : TX_STOP;
            end else begin
              tx_idx_next = tx_idx_reg + 1'b1;
            end
          end
          TX_PARITY: tx_state_next = TX_STOP;
          TX_STOP: begin
            if (tx_idx_reg == STOP_LAST) tx_state_next = TX_IDLE;
            else                         tx_idx_next   = tx_idx_reg + 1'b1;
          end
          default:   tx_state_next = TX_IDLE;
        endcase
      end
    end
  end

  // Line value is derived from the next state so the registered output
  // changes on the same edge as the state (start bit right after handshake).
  always_comb begin
    tx_par = (PARITY == PAR_ODD) ? ~(^tx_data_next) : ^tx_data_next;
    case (tx_state_next)
      TX_START:  uart_tx_next = 1'b0;
      TX_DATA:   uart_tx_next = tx_data_next[tx_idx_next];
      TX_PARITY: uart_tx_next = tx_par;
      default:   uart_tx_next = 1'b1;
    endcase
  end

  assign uart_tx = uart_tx_reg;

  // ---------------------------------------------------------------- RX path
  logic                 rx_meta_reg, rxs_reg;
  uart_rx_state_t       rx_state_reg, rx_state_next;
  logic [OW-1:0]        rx_os_reg, rx_os_next;
  logic [IW-1:0]        rx_idx_reg, rx_idx_next;
  logic [DATA_BITS-1:0] rx_shift_reg, rx_shift_next;
  logic                 rx_par_reg, rx_par_next;
  logic [DATA_BITS-1:0] rx_data_reg, rx_data_next;
  logic                 rx_valid_reg, rx_valid_next;
  logic                 rx_perr_reg, rx_perr_next;
  logic                 rx_ferr_reg, rx_ferr_next;
  logic                 rx_par_exp;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rx_meta_reg  <= 1'b1;
      rxs_reg      <= 1'b1;
      rx_state_reg <= RX_IDLE;
      rx_os_reg    <= '0;
      rx_idx_reg   <= '0;
      rx_shift_reg <= '0;
      rx_par_reg   <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      rx_perr_reg  <= 1'b0;
      rx_ferr_reg  <= 1'b0;
    end else begin
      rx_meta_reg  <= uart_rx;
      rxs_reg      <= rx_meta_reg;
      rx_state_reg <= rx_state_next;
      rx_os_reg    <= rx_os_next;
      rx_idx_reg   <= rx_idx_next;
      rx_shift_reg <= rx_shift_next;
      rx_par_reg   <= rx_par_next;
      rx_data_reg  <= rx_data_next;
      rx_valid_reg <= rx_valid_next;
      rx_perr_reg  <= rx_perr_next;
      rx_ferr_reg  <= rx_ferr_next;
    end
  end

  assign rx_par_exp = (PARITY == PAR_ODD) ? ~(^rx_shift_reg) : ^rx_shift_reg;

  // After the half-bit start recheck the tick counter is re-zeroed, so every
  // later sample at OS_LAST lands in the middle of its bit.
  always_comb begin
    rx_state_next = rx_state_reg;
    rx_os_next    = rx_os_reg;
    rx_idx_next   = rx_idx_reg;
    rx_shift_next = rx_shift_reg;
    rx_par_next   = rx_par_reg;
    rx_data_next  = rx_data_reg;
    rx_valid_next = 1'b0;
    rx_perr_next  = rx_perr_reg;
    rx_ferr_next  = rx_ferr_reg;
    if (tick) begin
      rx_os_next = rx_os_reg + 1'b1;
      case (rx_state_reg)
        RX_IDLE: begin
          rx_os_next = '0;
          if (!rxs_reg) rx_state_next = RX_START;
        end
        RX_START: begin
          if (rx_os_reg == OS_HALF) begin
            rx_os_next    = '0;
            rx_idx_next   = '0;
            rx_state_next = rxs_reg ? RX_IDLE : RX_DATA;
          end
        end
        RX_DATA: begin
          if (rx_os_reg == OS_LAST) begin
            rx_os_next    = '0;
            rx_shift_next = {rxs_reg, rx_shift_reg[DATA_BITS-1:1]};
            if (rx_idx_reg == DATA_LAST) begin
              rx_idx_next   = '0;
              rx_state_next = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
            end else begin
              rx_idx_next = rx_idx_reg + 1'b1;
            end
          end
        end
        RX_PARITY: begin
          if (rx_os_reg == OS_LAST) begin
            rx_os_next    = '0;
            rx_par_next   = rxs_reg;
            rx_state_next = RX_STOP;
          end
        end
        RX_STOP: begin
          if (rx_os_reg == OS_LAST) begin
            rx_os_next    = '0;
            rx_valid_next = 1'b1;
            rx_data_next  = rx_shift_reg;
            rx_perr_next  = (PARITY != PAR_NONE) && (rx_par_reg != rx_par_exp);
            rx_ferr_next  = !rxs_reg;
            // A low stop bit may be a break: wait for idle before rearming.
            rx_state_next = rxs_reg ? RX_IDLE : RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          rx_os_next = '0;
          if (rxs_reg) rx_state_next = RX_IDLE;
        end
        default: rx_state_next = RX_IDLE;
      endcase
    end
  end

  assign rx_data       = rx_data_reg;
  assign rx_valid      = rx_valid_reg;
  assign rx_parity_err = rx_perr_reg;
  assign rx_frame_err  = rx_ferr_reg;

endmodule

// File: tb/tb_uart_xcvr.sv
// tb_uart_xcvr: directed self-checking bench for uart_xcvr.
// dut0: 8N1 (TX capture, loopback, RX errors, glitch, reset mid-frame)
// dut1: even parity, 2 stop bits (TX capture, RX parity checks driven by bench)
// dut2: odd parity, 2 stop bits (TX capture, self loopback)
module tb_uart_xcvr;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic [2:0] tx_valid = 3'b000;
  logic       rx_drv0 = 1'b1;
  logic       rx_drv1 = 1'b1;
  logic       loop0 = 1'b0;

  wire  [2:0] tx_ready, tx_line, rx_valid, rx_perr, rx_ferr;
  wire  [7:0] rx_data0, rx_data1, rx_data2;
  wire        rx_in0 = loop0 ? tx_line[0] : rx_drv0;

  int errors = 0;
  int checks = 0;

  logic [9:0] q0[$];
  logic [9:0] q1[$];
  logic [9:0] q2[$];

  always #5 clk = ~clk;

  uart_xcvr #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
              .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_in0), .uart_tx(tx_line[0]),
    .tx_data(tx_data), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]),
    .rx_data(rx_data0), .rx_valid(rx_valid[0]),
    .rx_parity_err(rx_perr[0]), .rx_frame_err(rx_ferr[0]));

  uart_xcvr #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
              .DATA_BITS(8), .PARITY(1), .STOP_BITS(2)) dut1 (
    .clk(clk), .reset_n(reset_n), .uart_rx(rx_drv1), .uart_tx(tx_line[1]),
    .tx_data(tx_data), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]),
    .rx_data(rx_data1), .rx_valid(rx_valid[1]),
    .rx_parity_err(rx_perr[1]), .rx_frame_err(rx_ferr[1]));

  uart_xcvr #(.CLK_FREQ(1600000), .BAUD_RATE(100000), .OVERSAMPLE(16),
              .DATA_BITS(8), .PARITY(2), .STOP_BITS(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .uart_rx(tx_line[2]), .uart_tx(tx_line[2]),
    .tx_data(tx_data), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]),
    .rx_data(rx_data2), .rx_valid(rx_valid[2]),
    .rx_parity_err(rx_perr[2]), .rx_frame_err(rx_ferr[2]));

  // Received frames: {frame_err, parity_err, data}
  always @(negedge clk) begin
    if (rx_valid[0]) q0.push_back({rx_ferr[0], rx_perr[0], rx_data0});
    if (rx_valid[1]) q1.push_back({rx_ferr[1], rx_perr[1], rx_data1});
    if (rx_valid[2]) q2.push_back({rx_ferr[2], rx_perr[2], rx_data2});
  end

  // Drive n bits (bit 0 first) onto a bench-driven RX line, 16 clocks each.
  task automatic drive_rx(input int sel, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (sel == 0) rx_drv0 = bits[i];
      else          rx_drv1 = bits[i];
      repeat (16) @(negedge clk);
    end
  endtask

  task automatic test_reset;
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    checks++; if (tx_line !== 3'b111) begin errors++; $display("FAIL reset_uart_tx: got %b expected 111", tx_line); end
    checks++; if (tx_ready !== 3'b111) begin errors++; $display("FAIL reset_tx_ready: got %b expected 111", tx_ready); end
    checks++; if (rx_valid !== 3'b000) begin errors++; $display("FAIL reset_rx_valid: got %b expected 000", rx_valid); end
    checks++; if ({rx_perr, rx_ferr} !== 6'b0) begin errors++; $display("FAIL reset_err_flags: got %b expected 000000", {rx_perr, rx_ferr}); end
    checks++; if (rx_data0 !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data0); end
  endtask

  // Table: 8N1, even+2stop, odd+2stop, all sending 0xA5. Frame vectors are
  // bit 0 = start, LSB-first data, [parity], stop bits.
  task automatic test_tx_frames;
    int         sel_t[3]   = '{0, 1, 2};
    logic [11:0] frame_t[3] = '{12'b11_1_10100101_0, 12'b11_0_10100101_0, 12'b11_1_10100101_0};
    int         nbits_t[3] = '{10, 12, 12};
    int         rdy_t[3]   = '{160, 192, 192};
    for (int t = 0; t < 3; t++) begin
      logic [255:0] line;
      logic [11:0]  frame;
      int           ready_low;
      int           sel;
      sel = sel_t[t];
      frame = frame_t[t];
      ready_low = 0;
      @(negedge clk);
      tx_data = 8'hA5;
      tx_valid[sel] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      tx_valid[sel] = 1'b0;
      tx_data = 8'h00;
      for (int i = 0; i < 256; i++) begin
        line[i] = tx_line[sel];
        if (!tx_ready[sel]) ready_low++;
        @(negedge clk);
      end
      for (int p = 0; p < 16; p++) begin
        logic e;
        e = (p < nbits_t[t]) ? frame[p] : 1'b1;
        checks++;
        if (line[p*16 +: 16] !== {16{e}}) begin
          errors++;
          $display("FAIL tx_bit dut%0d period %0d: got %h expected %h", sel, p, line[p*16 +: 16], {16{e}});
        end
      end
      checks++;
      if (ready_low != rdy_t[t]) begin
        errors++;
        $display("FAIL tx_ready_low dut%0d: got %0d expected %0d", sel, ready_low, rdy_t[t]);
      end
    end
    // dut2 loops its own odd-parity frame back: A5 with no errors.
    checks++;
    if (q2.size() != 1 || q2[0] !== 10'h0A5) begin
      errors++;
      $display("FAIL odd_loopback: got size %0d first %h expected size 1 first 0a5", q2.size(), (q2.size() > 0) ? q2[0] : 10'h3FF);
    end
  endtask

  task automatic test_back_to_back;
    int gap;
    int n0;
    logic [9:0] got;
    n0 = q0.size();
    loop0 = 1'b1;
    @(negedge clk);
    tx_data = 8'h3C;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_data = 8'hC3;
    gap = 0;
    while (!tx_ready[0] && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    checks++;
    if (gap != 160) begin errors++; $display("FAIL b2b_ready_gap: got %0d expected 160", gap); end
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (250) @(negedge clk);
    checks++;
    if (q0.size() != n0 + 2) begin errors++; $display("FAIL b2b_rx_count: got %0d expected %0d", q0.size(), n0 + 2); end
    got = (q0.size() > n0) ? q0[n0] : 10'h3FF;
    checks++;
    if (got !== 10'h03C) begin errors++; $display("FAIL b2b_rx_first: got %h expected 03c", got); end
    got = (q0.size() > n0 + 1) ? q0[n0 + 1] : 10'h3FF;
    checks++;
    if (got !== 10'h0C3) begin errors++; $display("FAIL b2b_rx_second: got %h expected 0c3", got); end
    loop0 = 1'b0;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_frame_err;
    int n0;
    logic [9:0] got;
    n0 = q0.size();
    drive_rx(0, 16'(10'b0_01010101_0), 10);
    repeat (500) @(negedge clk);
    checks++;
    if (q0.size() != n0 + 1) begin errors++; $display("FAIL frame_err_count_low: got %0d expected %0d", q0.size(), n0 + 1); end
    got = (q0.size() > n0) ? q0[n0] : 10'h3FF;
    checks++;
    if (got !== 10'h255) begin errors++; $display("FAIL frame_err_entry: got %h expected 255", got); end
    rx_drv0 = 1'b1;
    repeat (60) @(negedge clk);
    checks++;
    if (q0.size() != n0 + 1) begin errors++; $display("FAIL frame_err_count_after: got %0d expected %0d", q0.size(), n0 + 1); end
  endtask

  task automatic test_glitch;
    int n0;
    logic [9:0] got;
    n0 = q0.size();
    rx_drv0 = 1'b0;
    repeat (4) @(negedge clk);
    rx_drv0 = 1'b1;
    repeat (40) @(negedge clk);
    checks++;
    if (q0.size() != n0) begin errors++; $display("FAIL glitch_no_valid: got %0d expected %0d", q0.size(), n0); end
    drive_rx(0, 16'(10'b1_10000001_0), 10);
    rx_drv0 = 1'b1;
    repeat (20) @(negedge clk);
    got = (q0.size() > n0) ? q0[n0] : 10'h3FF;
    checks++;
    if (q0.size() != n0 + 1 || got !== 10'h081) begin
      errors++; $display("FAIL glitch_then_frame: got size %0d entry %h expected size %0d entry 081", q0.size(), got, n0 + 1);
    end
  endtask

  task automatic test_parity_err;
    logic [9:0] got;
    drive_rx(1, 16'(11'b1_1_10100101_0), 11);
    rx_drv1 = 1'b1;
    repeat (20) @(negedge clk);
    got = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    checks++;
    if (got !== 10'h1A5) begin errors++; $display("FAIL parity_err_entry: got %h expected 1a5", got); end
    repeat (100) @(negedge clk);
    checks++;
    if (rx_perr[1] !== 1'b1) begin errors++; $display("FAIL parity_err_hold: got %b expected 1", rx_perr[1]); end
    drive_rx(1, 16'(11'b1_0_10100101_0), 11);
    rx_drv1 = 1'b1;
    repeat (20) @(negedge clk);
    got = (q1.size() > 0) ? q1.pop_front() : 10'h3FF;
    checks++;
    if (got !== 10'h0A5) begin errors++; $display("FAIL parity_ok_entry: got %h expected 0a5", got); end
  endtask

  task automatic test_reset_mid_tx;
    int n0;
    n0 = q0.size();
    loop0 = 1'b1;
    @(negedge clk);
    tx_data = 8'h00;
    tx_valid[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    tx_valid[0] = 1'b0;
    repeat (39) @(negedge clk);
    checks++;
    if (tx_line[0] !== 1'b0) begin errors++; $display("FAIL mid_tx_line_busy: got %b expected 0", tx_line[0]); end
    reset_n = 1'b0;
    @(negedge clk);
    checks++;
    if (tx_line[0] !== 1'b1) begin errors++; $display("FAIL mid_tx_reset_line: got %b expected 1", tx_line[0]); end
    checks++;
    if (tx_ready[0] !== 1'b1) begin errors++; $display("FAIL mid_tx_reset_ready: got %b expected 1", tx_ready[0]); end
    reset_n = 1'b1;
    repeat (300) @(negedge clk);
    checks++;
    if (q0.size() != n0) begin errors++; $display("FAIL mid_tx_no_rx_valid: got %0d expected %0d", q0.size(), n0); end
    loop0 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_tx_frames();
    test_back_to_back();
    test_frame_err();
    test_glitch();
    test_parity_err();
    test_reset_mid_tx();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_xcvr.md
Name: uart_xcvr

Overview:
Parametrised full-duplex UART for the SoC console and debug link. It has a TX path with a valid/ready handshake, and an RX path with a synchroniser, oversampling and error detection. Data width, parity mode and stop-bit count are parametrised, and both paths share one oversampling tick generator. It connects directly to the memory-mapped peripheral bus glue.

Parameters:
CLK_FREQ, 65000000, system clock frequency in Hz
BAUD_RATE, 230400, line rate in bits/s
OVERSAMPLE, 16, ticks per bit period; even, >= 4
DATA_BITS, 8, payload bits per frame; legal values 5..8
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2; applies to TX only, RX always checks exactly one stop bit

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
uart_rx  input  1  asynchronous serial input, idle high
uart_tx  output  1  serial output, idle high, registered
tx_data  input  DATA_BITS  byte to transmit
tx_valid  input  1  tx_data valid
tx_ready  output  1  transmitter can accept a byte
rx_data  output  DATA_BITS  last received payload, held until the next frame completes
rx_valid  output  1  one-cycle pulse: a frame completed
rx_parity_err  output  1  parity mismatch on this frame; qualified by rx_valid
rx_frame_err  output  1  stop bit sampled low; qualified by rx_valid

Behaviour:
- Reset: all FSMs go to IDLE. uart_tx=1, tx_ready=1, rx_valid=0, both error flags 0, rx_data=0, synchroniser flops=1, tick counter=0.
- Tick generator:
  - DIV = round(CLK_FREQ / (BAUD_RATE*OVERSAMPLE)), computed at elaboration. DIV < 1 is a fatal elaboration error.
  - tick pulses for one cycle every DIV clocks. It is free-running, except it restarts on a TX handshake.
- TX FSM (IDLE, START, DATA, PARITY, STOP):
  - tx_ready = (state == IDLE).
  - Handshake = tx_valid && tx_ready. On handshake, latch tx_data and go to START. uart_tx goes 0 on the next clock.
  - Each bit lasts exactly OVERSAMPLE ticks = OVERSAMPLE*DIV clocks.
  - Bit order: DATA is LSB first for DATA_BITS bits. PARITY is skipped when PARITY=0; otherwise the bit is XOR(data) for even, ~XOR(data) for odd. STOP holds 1 for STOP_BITS bit times.
  - After the final stop bit, return to IDLE. tx_ready=1 on that cycle, so back-to-back frames are accepted with no idle gap.
  - tx_data and tx_valid are ignored while not ready.
- RX synchroniser: 2 flops on uart_rx. All RX logic uses the synchronised value rxs.
- RX FSM (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH), evaluated on tick:
  - IDLE: on a tick with rxs=0, go to START with sample counter=0.
  - START: after OVERSAMPLE/2 ticks, recheck rxs. If rxs=1 it is a false start: go to IDLE with no rx_valid. If rxs=0, go to DATA.
  - DATA: sample every OVERSAMPLE ticks, i.e. at mid-bit. Shift bits in LSB first, DATA_BITS samples.
  - PARITY: present only when PARITY!=0. Sample the bit and compare against the computed parity.
  - STOP: sample one bit. On the next clock, load rx_data, pulse rx_valid for one cycle and set both error flags. Then go to IDLE if the stop bit was 1, or to WAIT_HIGH if it was 0.
  - WAIT_HIGH: stay until rxs=1. This prevents a break condition from generating repeated frames.
  - A frame with a framing error still delivers rx_data and rx_valid, with rx_frame_err=1.
  - Error flags hold their values until the next rx_valid.
- TX and RX are fully independent. Simultaneous activity on both paths is legal.
- Reset mid-frame: uart_tx returns to 1 on the cycle after reset is sampled. A partial RX frame is discarded with no rx_valid.

Decomposition:
- Package uart_pkg holds:
  - uart_tx_state_t and uart_rx_state_t enums
  - parity mode constants PAR_NONE/PAR_EVEN/PAR_ODD
  - a function computing DIV from the parameters
- Sub-module uart_baud_gen (tick generator: DIV counter with restart input) is instantiated once.
- TX and RX FSMs live in uart_xcvr.

Test Plan:
All scenarios use CLK_FREQ=1600000, BAUD_RATE=100000, OVERSAMPLE=16 (DIV=1, 16 clocks per bit).
- TX, 8N1: send 0xA5.
  -> uart_tx: 0 for 16 clocks, then 1,0,1,0,0,1,0,1 at 16 clocks each, then 1 for 16 clocks.
  -> tx_ready low for exactly 160 clocks.
- TX parity and stop bits:
  - PARITY=1, send 0xA5 -> parity bit 0.
  - PARITY=2, send 0xA5 -> parity bit 1.
  - STOP_BITS=2 -> stop high for 32 clocks; tx_ready low for 192 clocks with PARITY=1 or 2.
- RX loopback (uart_rx=uart_tx): send 0x3C then 0xC3 back-to-back.
  -> two rx_valid pulses with rx_data 0x3C then 0xC3; both error flags 0.
- RX errors:
  - Drive a frame for 0x55 with the stop bit 0 -> rx_valid with rx_data=0x55, rx_frame_err=1. No further rx_valid while the line is held low for 500 clocks.
  - PARITY=1 with a wrong parity bit -> rx_parity_err=1.
- RX glitch: pulse uart_rx low for 4 clocks -> no rx_valid, and a following valid frame for 0x81 is received correctly.
- Reset mid-TX: assert reset_n=0 at clock 40 of a frame.
  -> uart_tx=1 and tx_ready=1 after one clock.
  -> no rx_valid from a partial loopback frame.
